// File: rtl/mem2_load_stage_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Shared types for the memory-2 load stage and its aligner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'd0,
    HALF_WORD = 2'd1,
    WORD      = 2'd2,
    DWORD     = 2'd3
  } byte_type_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } mem2_state_t;

endpackage

`default_nettype wire

// File: rtl/mem2_load_stage_align.sv
// ============================================================================
// Module      : load_align
// Description : Lane select plus sign/zero extension of a dcache read word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
  import mem_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] i_data,
  input  byte_type_t        i_byte_type,
  input  logic              i_is_signed,
  input  logic [OFF_W-1:0]  i_offset,
  output logic [DATA_W-1:0] o_data
);

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_word;
  logic [DATA_W-1:0] w_dword;
  logic [OFF_W-1:0]  w_half_off;

  assign w_byte     = 8'(i_data >> {i_offset, 3'b000});
  assign w_half_off = {i_offset[OFF_W-1:1], 1'b0};
  assign w_half     = 16'(i_data >> {w_half_off, 3'b000});

  // A 32-bit datapath has a single word lane and cannot return a doubleword.
  generate
    if (DATA_W == 64) begin : g_dw64
      assign w_word  = i_offset[OFF_W-1] ? i_data[63:32] : i_data[31:0];
      assign w_dword = i_data;
    end else begin : g_dw32
      assign w_word  = i_data[31:0];
      assign w_dword = '0;
    end
  endgenerate

  always_comb begin
    o_data = '0;
    case (i_byte_type)
      BYTE:      o_data = i_is_signed ? DATA_W'($signed(w_byte)) : DATA_W'(w_byte);
      HALF_WORD: o_data = i_is_signed ? DATA_W'($signed(w_half)) : DATA_W'(w_half);
      WORD:      o_data = i_is_signed ? DATA_W'($signed(w_word)) : DATA_W'(w_word);
      DWORD:     o_data = w_dword;
      default:   o_data = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem2_load_stage.sv
// ============================================================================
// Module      : mem2_load_stage
// Description : Memory-2 stage register with outstanding dcache load tracking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem2_load_stage
  import mem_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              in_valid,
  input  logic              in_is_load,
  input  logic              in_excp,
  input  logic [1:0]        in_byte_type,
  input  logic              in_is_signed,
  input  logic [OFF_W-1:0]  in_offset,
  input  logic [DATA_W-1:0] in_ex_out,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_pc_plus4,
  input  logic              in_is_wr_rd,
  input  logic              in_is_wr_rd_pc_plus4,
  input  logic [4:0]        in_rd,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              dcache_stall,
  output logic              fwd_valid,
  output logic              fwd_pending,
  output logic [4:0]        fwd_idx,
  output logic [DATA_W-1:0] fwd_data,
  output logic              out_valid,
  output logic              out_is_wr_rd,
  output logic [4:0]        out_rd,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       out_pc,
  output logic              out_excp
);

  logic              r_valid;
  logic              r_is_load;
  logic              r_excp;
  byte_type_t        r_byte_type;
  logic              r_is_signed;
  logic [OFF_W-1:0]  r_offset;
  logic [DATA_W-1:0] r_ex_out;
  logic [31:0]       r_pc;
  logic [31:0]       r_pc_plus4;
  logic              r_is_wr_rd;
  logic              r_is_wr_rd_pc4;
  logic [4:0]        r_rd;

  mem2_state_t       r_state;
  logic [DATA_W-1:0] r_hold;

  logic              w_wait_load;
  logic              w_data_avail;
  logic              w_load_busy;
  logic [DATA_W-1:0] w_raw;
  logic [DATA_W-1:0] w_aligned;
  logic [DATA_W-1:0] w_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (flush_in) begin
      r_valid <= 1'b0;
    end else if (!stall_in) begin
      if (r_state == DRAIN) begin
        r_valid <= 1'b0;
      end else begin
        r_valid        <= in_valid;
        r_is_load      <= in_is_load;
        r_excp         <= in_excp;
        r_byte_type    <= byte_type_t'(in_byte_type);
        r_is_signed    <= in_is_signed;
        r_offset       <= in_offset;
        r_ex_out       <= in_ex_out;
        r_pc           <= in_pc;
        r_pc_plus4     <= in_pc_plus4;
        r_is_wr_rd     <= in_is_wr_rd;
        r_is_wr_rd_pc4 <= in_is_wr_rd_pc_plus4;
        r_rd           <= in_rd;
      end
    end
  end

  assign w_wait_load  = r_valid & r_is_load & ~r_excp;
  assign w_data_avail = (r_state == HOLD) |
                        (rsp_valid & ((r_state == IDLE) | (r_state == WAIT)));
  assign w_load_busy  = w_wait_load & ~w_data_avail;

  // A response consumed while the stage advances passes straight through;
  // it is only parked in HOLD when the entry cannot leave this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_hold  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_wait_load) begin
            if (rsp_valid) begin
              if (!flush_in && stall_in) begin
                r_state <= HOLD;
                r_hold  <= rsp_data;
              end
            end else begin
              r_state <= flush_in ? DRAIN : WAIT;
            end
          end
        end
        WAIT: begin
          if (rsp_valid) begin
            if (!flush_in && stall_in) begin
              r_state <= HOLD;
              r_hold  <= rsp_data;
            end else begin
              r_state <= IDLE;
            end
          end else if (flush_in) begin
            r_state <= DRAIN;
          end
        end
        HOLD: begin
          if (!stall_in || flush_in) begin
            r_state <= IDLE;
          end
        end
        DRAIN: begin
          if (rsp_valid) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_raw = (r_state == HOLD) ? r_hold : rsp_data;

  load_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .i_data     (w_raw),
    .i_byte_type(r_byte_type),
    .i_is_signed(r_is_signed),
    .i_offset   (r_offset),
    .o_data     (w_aligned)
  );

  always_comb begin
    w_data = r_ex_out;
    if (r_is_wr_rd_pc4) begin
      w_data = DATA_W'(r_pc_plus4);
    end else if (r_is_load && !r_excp) begin
      w_data = w_aligned;
    end
  end

  assign dcache_stall = w_load_busy | (r_state == DRAIN);
  assign fwd_valid    = r_valid & r_is_wr_rd;
  assign fwd_pending  = fwd_valid & w_load_busy;
  assign fwd_idx      = r_rd;
  assign fwd_data     = w_data;
  assign out_valid    = r_valid & ~flush_in & ~dcache_stall;
  assign out_is_wr_rd = r_is_wr_rd;
  assign out_rd       = r_rd;
  assign out_data     = w_data;
  assign out_pc       = r_pc;
  assign out_excp     = r_excp;

endmodule

`default_nettype wire

// File: tb/tb_mem2_load_stage.sv
// ============================================================================
// Module      : tb_mem2_load_stage
// Description : Directed bench for mem2_load_stage at DATA_W=32 and 64.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem2_load_stage;
  import mem_pkg::*;

  logic        clk;
  logic        rst, tb_stall, flush_in;
  logic        in_valid, in_is_load, in_excp, in_is_signed;
  logic        in_is_wr_rd, in_is_wr_rd_pc_plus4, rsp_valid;
  logic [1:0]  in_byte_type;
  logic [2:0]  in_offset;
  logic [63:0] in_ex_out, rsp_data;
  logic [31:0] in_pc, in_pc_plus4;
  logic [4:0]  in_rd;

  logic        s32_stall, s64_stall;
  logic        a_dcache_stall, a_fwd_valid, a_fwd_pending, a_out_valid, a_out_is_wr_rd, a_out_excp;
  logic [4:0]  a_fwd_idx, a_out_rd;
  logic [31:0] a_fwd_data, a_out_data, a_out_pc;
  logic        b_dcache_stall, b_fwd_valid, b_fwd_pending, b_out_valid, b_out_is_wr_rd, b_out_excp;
  logic [4:0]  b_fwd_idx, b_out_rd;
  logic [63:0] b_fwd_data, b_out_data;
  logic [31:0] b_out_pc;

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The pipeline's stall already includes the stage's own dcache_stall.
  assign s32_stall = tb_stall | a_dcache_stall;
  assign s64_stall = tb_stall | b_dcache_stall;

  mem2_load_stage #(.DATA_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .stall_in(s32_stall), .flush_in(flush_in),
    .in_valid(in_valid), .in_is_load(in_is_load), .in_excp(in_excp),
    .in_byte_type(in_byte_type), .in_is_signed(in_is_signed),
    .in_offset(in_offset[1:0]), .in_ex_out(in_ex_out[31:0]),
    .in_pc(in_pc), .in_pc_plus4(in_pc_plus4), .in_is_wr_rd(in_is_wr_rd),
    .in_is_wr_rd_pc_plus4(in_is_wr_rd_pc_plus4), .in_rd(in_rd),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data[31:0]),
    .dcache_stall(a_dcache_stall), .fwd_valid(a_fwd_valid), .fwd_pending(a_fwd_pending),
    .fwd_idx(a_fwd_idx), .fwd_data(a_fwd_data), .out_valid(a_out_valid),
    .out_is_wr_rd(a_out_is_wr_rd), .out_rd(a_out_rd), .out_data(a_out_data),
    .out_pc(a_out_pc), .out_excp(a_out_excp)
  );

  mem2_load_stage #(.DATA_W(64)) u_dut64 (
    .clk(clk), .rst(rst), .stall_in(s64_stall), .flush_in(flush_in),
    .in_valid(in_valid), .in_is_load(in_is_load), .in_excp(in_excp),
    .in_byte_type(in_byte_type), .in_is_signed(in_is_signed),
    .in_offset(in_offset), .in_ex_out(in_ex_out),
    .in_pc(in_pc), .in_pc_plus4(in_pc_plus4), .in_is_wr_rd(in_is_wr_rd),
    .in_is_wr_rd_pc_plus4(in_is_wr_rd_pc_plus4), .in_rd(in_rd),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .dcache_stall(b_dcache_stall), .fwd_valid(b_fwd_valid), .fwd_pending(b_fwd_pending),
    .fwd_idx(b_fwd_idx), .fwd_data(b_fwd_data), .out_valid(b_out_valid),
    .out_is_wr_rd(b_out_is_wr_rd), .out_rd(b_out_rd), .out_data(b_out_data),
    .out_pc(b_out_pc), .out_excp(b_out_excp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    in_valid = 0; in_is_load = 0; in_excp = 0; in_byte_type = 2'd0; in_is_signed = 0;
    in_offset = '0; in_ex_out = '0; in_pc = '0; in_pc_plus4 = '0; in_is_wr_rd = 0;
    in_is_wr_rd_pc_plus4 = 0; in_rd = '0;
  endtask

  task automatic enter(input logic ld, input logic ex, input logic [1:0] bt, input logic sg,
                       input logic [2:0] off, input logic wr, input logic p4, input logic [4:0] rd,
                       input logic [63:0] exo, input logic [31:0] pc, input logic [31:0] pc4);
    in_valid = 1; in_is_load = ld; in_excp = ex; in_byte_type = bt; in_is_signed = sg;
    in_offset = off; in_is_wr_rd = wr; in_is_wr_rd_pc_plus4 = p4; in_rd = rd;
    in_ex_out = exo; in_pc = pc; in_pc_plus4 = pc4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; tb_stall = 0; flush_in = 0; rsp_valid = 0; rsp_data = '0;
    clr_in();
    tick(); tick();
    rst = 0; #1;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_dcache_stall", a_dcache_stall, 0);
    chk("rst_fwd_valid", a_fwd_valid, 0);
    chk("rst_out_valid64", b_out_valid, 0);

    // LB signed, offset 2, response 3 cycles after entry
    enter(1, 0, BYTE, 1, 3'd2, 1, 0, 5'd5, 64'h0, 32'h100, 32'h104);
    tick(); in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lb_wait_stall", a_dcache_stall, 1);
      chk("lb_wait_pending", a_fwd_pending, 1);
      chk("lb_wait_out_valid", a_out_valid, 0);
      tick();
    end
    rsp_valid = 1; rsp_data = 64'h12F45678; #1;
    chk("lb_out_valid", a_out_valid, 1);
    chk("lb_out_data", a_out_data, 64'hFFFFFFF4);
    chk("lb_pending_clear", a_fwd_pending, 0);
    chk("lb_stall_clear", a_dcache_stall, 0);
    chk("lb_out_rd", a_out_rd, 5);
    tick(); rsp_valid = 0;

    // LWU offset 4 on the 64-bit datapath, response in the entry cycle
    enter(1, 0, WORD, 0, 3'd4, 1, 0, 5'd6, 64'h0, 32'h200, 32'h204);
    tick(); in_valid = 0;
    rsp_valid = 1; rsp_data = 64'h89ABCDEF_01234567; #1;
    chk("lwu64_out_data", b_out_data, 64'h00000000_89ABCDEF);
    chk("lwu64_out_valid", b_out_valid, 1);
    chk("lw32_off0_data", a_out_data, 64'h01234567);
    tick(); rsp_valid = 0;

    // DWORD: full word on 64, zero on 32
    enter(1, 0, DWORD, 0, 3'd0, 1, 0, 5'd10, 64'h0, 32'h300, 32'h304);
    tick(); in_valid = 0;
    rsp_valid = 1; rsp_data = 64'hFEDCBA98_76543210; #1;
    chk("ld32_zero", a_out_data, 64'h0);
    chk("ld64_data", b_out_data, 64'hFEDCBA98_76543210);
    tick(); rsp_valid = 0;

    // LH signed, response under downstream stall -> HOLD
    enter(1, 0, HALF_WORD, 1, 3'd2, 1, 0, 5'd7, 64'h0, 32'h400, 32'h404);
    tick(); in_valid = 0;
    tb_stall = 1; rsp_valid = 1; rsp_data = 64'h80011234; #1;
    chk("lh_rsp_data", a_out_data, 64'hFFFF8001);
    tick(); rsp_valid = 0; rsp_data = 64'hDEADBEEF_DEADBEEF;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("hold_data", a_out_data, 64'hFFFF8001);
      chk("hold_stall", a_dcache_stall, 0);
      chk("hold_pending", a_fwd_pending, 0);
      tick();
    end
    tb_stall = 0; #1;
    chk("hold_release_valid", a_out_valid, 1);
    chk("hold_release_data", a_out_data, 64'hFFFF8001);
    chk("hold_release_rd", a_out_rd, 7);
    tick(); #1;
    chk("hold_after_valid", a_out_valid, 0);

    // Flush during WAIT, next load waits behind DRAIN for its own response
    enter(1, 0, BYTE, 0, 3'd0, 1, 0, 5'd8, 64'h0, 32'h500, 32'h504);
    tick();
    enter(1, 0, WORD, 0, 3'd0, 1, 0, 5'd9, 64'h0, 32'h508, 32'h50C);
    tick();
    flush_in = 1; #1;
    chk("flush_out_valid", a_out_valid, 0);
    tick(); flush_in = 0; #1;
    chk("drain_stall", a_dcache_stall, 1);
    chk("drain_fwd_valid", a_fwd_valid, 0);
    tick();
    rsp_valid = 1; rsp_data = 64'hAAAAAAAA; #1;
    chk("stale_out_valid", a_out_valid, 0);
    chk("stale_stall", a_dcache_stall, 1);
    tick(); rsp_valid = 0; #1;
    chk("post_drain_stall", a_dcache_stall, 0);
    chk("post_drain_valid", a_out_valid, 0);
    tick(); in_valid = 0; #1;
    chk("newload_stall", a_dcache_stall, 1);
    chk("newload_pending", a_fwd_pending, 1);
    chk("newload_idx", a_fwd_idx, 9);
    tick(); #1;
    chk("newload_wait_stall", a_dcache_stall, 1);
    rsp_valid = 1; rsp_data = 64'h55667788; #1;
    chk("newload_valid", a_out_valid, 1);
    chk("newload_data", a_out_data, 64'h55667788);
    chk("newload_rd", a_out_rd, 9);
    tick(); rsp_valid = 0;

    // JAL: rd <- pc+4
    enter(0, 0, WORD, 0, 3'd0, 1, 1, 5'd1, 64'h12345, 32'h1C000004, 32'h1C000008);
    tick(); in_valid = 0; #1;
    chk("jal_fwd_valid", a_fwd_valid, 1);
    chk("jal_fwd_idx", a_fwd_idx, 1);
    chk("jal_fwd_data", a_fwd_data, 64'h1C000008);
    chk("jal_fwd_data64", b_fwd_data, 64'h1C000008);
    chk("jal_pending", a_fwd_pending, 0);
    chk("jal_stall", a_dcache_stall, 0);
    chk("jal_out_valid", a_out_valid, 1);
    chk("jal_out_pc", a_out_pc, 64'h1C000004);

    // ALU op, then flushed in place
    enter(0, 0, WORD, 0, 3'd0, 1, 0, 5'd3, 64'hCAFEF00D, 32'h600, 32'h604);
    tick(); in_valid = 0; #1;
    chk("alu_data", a_out_data, 64'hCAFEF00D);
    chk("alu_is_wr_rd", a_out_is_wr_rd, 1);
    flush_in = 1; #1;
    chk("alu_flush_valid", a_out_valid, 0);
    tick(); flush_in = 0;

    // Excepting load: no dcache wait, ALU result passes
    enter(1, 1, WORD, 0, 3'd0, 1, 0, 5'd4, 64'h1111, 32'h700, 32'h704);
    tick(); in_valid = 0; #1;
    chk("excp_stall", a_dcache_stall, 0);
    chk("excp_flag", a_out_excp, 1);
    chk("excp_data", a_out_data, 64'h1111);
    chk("excp_valid", a_out_valid, 1);
    tick();

    // Reset while WAIT, then an orphan response in IDLE
    enter(1, 0, WORD, 0, 3'd0, 1, 0, 5'd11, 64'h0, 32'h800, 32'h804);
    tick(); in_valid = 0;
    tick();
    rst = 1; tick(); rst = 0; #1;
    chk("rstwait_out_valid", a_out_valid, 0);
    chk("rstwait_stall", a_dcache_stall, 0);
    rsp_valid = 1; rsp_data = 64'h77777777; #1;
    chk("orphan_out_valid", a_out_valid, 0);
    chk("orphan_stall", a_dcache_stall, 0);
    tick(); rsp_valid = 0; #1;
    chk("orphan_after_stall", a_dcache_stall, 0);
    chk("orphan_after_valid", a_out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
